// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern engine: bounce/rotate/bar/blink with speed scaling,
// pause, PWM-faded trail and a cycle-done strobe on step wrap.
module led_pattern_gen #(
    parameter int   CLK_IN_MHZ   = 125,
    parameter int   NUM_LEDS     = 8,
    parameter int   STEP_HZ      = 14,
    parameter logic LED_POLARITY = 1'b0,
    parameter int   SIM_MODE     = 0
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                enable_i,
    input  logic [1:0]          mode_i,
    input  logic [1:0]          speed_i,
    input  logic                trail_en_i,
    output logic [NUM_LEDS-1:0] display_o,
    output logic [5:0]          step_o,
    output logic                cycle_done_o
);

    localparam int TICK_DIV = CLK_IN_MHZ * 1_000_000 / STEP_HZ;
    localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    // mode | pattern
    // 0    | bounce
    // 1    | rotate
    // 2    | bar
    // 3    | blink
    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_BAR    = 2'd2;

    logic [PW-1:0]       presc_q;
    logic [1:0]          div_q;
    logic [1:0]          mode_q;
    logic [5:0]          step_q;
    logic [5:0]          hist1_q;
    logic [5:0]          hist2_q;
    logic                hist1_vld_q;
    logic                hist2_vld_q;
    logic [3:0]          pwm_q;
    logic [NUM_LEDS-1:0] display_q;
    logic                cycle_done_q;

    logic                mode_chg;
    logic                presc_tc;
    logic                tick;
    logic                step_adv;
    logic [6:0]          step_len;
    logic                step_last;
    logic [5:0]          head;
    logic [NUM_LEDS-1:0] lit;

    assign mode_chg = (mode_i != mode_q);
    assign presc_tc = (presc_q == PW'(TICK_DIV - 1));
    assign tick     = enable_i && ((SIM_MODE != 0) || presc_tc);
    // ">=" also catches a divider left above a freshly lowered speed_i
    assign step_adv = tick && (div_q >= speed_i);

    always_comb begin
        case (mode_q)
            MODE_BOUNCE: step_len = 7'(2 * NUM_LEDS - 2);
            MODE_ROTATE: step_len = 7'(NUM_LEDS);
            MODE_BAR:    step_len = 7'(2 * NUM_LEDS);
            default:     step_len = 7'd2;
        endcase
    end

    assign step_last = ({1'b0, step_q} == (step_len - 7'd1));

    assign head = ((mode_q == MODE_BOUNCE) && (step_q >= 6'(NUM_LEDS)))
                  ? (6'(2 * NUM_LEDS - 2) - step_q) : step_q;

    always_comb begin
        int k;
        lit = '0;
        k   = int'(step_q);
        case (mode_q)
            MODE_BOUNCE, MODE_ROTATE: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (6'(i) == head)
                        lit[i] = 1'b1;
                    else if (trail_en_i && hist1_vld_q && (pwm_q < 4'd4) && (6'(i) == hist1_q))
                        lit[i] = 1'b1;
                    else if (trail_en_i && hist2_vld_q && (pwm_q == 4'd0) && (6'(i) == hist2_q))
                        lit[i] = 1'b1;
                end
            end
            MODE_BAR: begin
                for (int i = 0; i < NUM_LEDS; i++)
                    lit[i] = (k < NUM_LEDS) ? (i <= k) : (i < 2 * NUM_LEDS - 1 - k);
            end
            default: lit = (step_q == 6'd0) ? '1 : '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q      <= '0;
            div_q        <= '0;
            mode_q       <= '0;
            step_q       <= '0;
            hist1_q      <= '0;
            hist2_q      <= '0;
            hist1_vld_q  <= 1'b0;
            hist2_vld_q  <= 1'b0;
            pwm_q        <= '0;
            display_q    <= {NUM_LEDS{~LED_POLARITY}};
            cycle_done_q <= 1'b0;
        end else begin
            pwm_q        <= pwm_q + 4'd1;
            mode_q       <= mode_i;
            display_q    <= LED_POLARITY ? lit : ~lit;
            cycle_done_q <= 1'b0;
            if (mode_chg) begin
                presc_q     <= '0;
                div_q       <= '0;
                step_q      <= '0;
                hist1_q     <= '0;
                hist2_q     <= '0;
                hist1_vld_q <= 1'b0;
                hist2_vld_q <= 1'b0;
            end else begin
                if (enable_i)
                    presc_q <= presc_tc ? '0 : presc_q + PW'(1);
                if (tick)
                    div_q <= (div_q >= speed_i) ? 2'd0 : div_q + 2'd1;
                if (step_adv) begin
                    step_q       <= step_last ? 6'd0 : step_q + 6'd1;
                    cycle_done_q <= step_last;
                    hist2_q      <= hist1_q;
                    hist2_vld_q  <= hist1_vld_q;
                    hist1_q      <= head;
                    hist1_vld_q  <= 1'b1;
                end
            end
        end
    end

    assign display_o    = display_q;
    assign step_o       = step_q;
    assign cycle_done_o = cycle_done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (SIM_MODE, 8 LEDs, active-low pins);
// expected outputs are queued per clock and popped at each falling edge.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [1:0] speed = 2'd0;
    logic       trail_en = 1'b0;
    logic [7:0] display;
    logic [5:0] step;
    logic       cycle_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         chk_disp;
        logic [7:0] disp;
        logic [5:0] stp;
        logic       cd;
        string      tag;
    } exp_t;

    exp_t sb[$];

    led_pattern_gen #(
        .CLK_IN_MHZ(125), .NUM_LEDS(8), .STEP_HZ(14),
        .LED_POLARITY(1'b0), .SIM_MODE(1)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .mode_i(mode),
        .speed_i(speed), .trail_en_i(trail_en), .display_o(display),
        .step_o(step), .cycle_done_o(cycle_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] onehot(int p);
        logic [7:0] v;
        v = 8'h00;
        v[p[2:0]] = 1'b1;
        return v;
    endfunction

    function automatic int bounce_pos(int s);
        return (s < 8) ? s : 14 - s;
    endfunction

    function automatic logic [7:0] bar_lit(int k);
        int   cnt;
        logic [8:0] t;
        cnt = (k < 8) ? k + 1 : 15 - k;
        t = (9'd1 << cnt) - 9'd1;
        return t[7:0];
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(bit cd_en, logic [7:0] d, int s, bit cd, string tag);
        exp_t e;
        e.chk_disp = cd_en;
        e.disp     = d;
        e.stp      = 6'(s);
        e.cd       = cd;
        e.tag      = tag;
        sb.push_back(e);
    endtask

    task automatic run(int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.chk_disp)
                    check({e.tag, "_disp"}, {24'd0, display}, {24'd0, e.disp});
                check({e.tag, "_step"}, {26'd0, step}, {26'd0, e.stp});
                check({e.tag, "_cd"}, {31'd0, cycle_done}, {31'd0, e.cd});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_disp", {24'd0, display}, 32'hFF);
        check("rst_step", {26'd0, step}, 32'd0);
        check("rst_cd", {31'd0, cycle_done}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int c_head, c_h1, c_h2, c_other;

        // bounce, speed 0, trail off: two full sweeps
        mode = 2'd0; speed = 2'd0; trail_en = 1'b0; enable = 1'b1;
        do_reset();
        for (int e = 1; e <= 30; e++)
            push(1, ~onehot(bounce_pos((e - 1) % 14)), e % 14, (e % 14) == 0, "bounce");
        run(30);

        // rotate, speed 2: first edge is the mode change
        mode = 2'd1; speed = 2'd2;
        do_reset();
        push(0, 8'h00, 0, 0, "rot_chg");
        for (int e = 2; e <= 50; e++)
            push(1, ~onehot(((e - 2) / 3) % 8), ((e - 1) / 3) % 8, ((e - 1) % 24) == 0, "rotate");
        run(50);

        // bar over 16 steps, step 15 dark
        mode = 2'd2; speed = 2'd0;
        do_reset();
        push(0, 8'h00, 0, 0, "bar_chg");
        for (int e = 2; e <= 34; e++)
            push(1, ~bar_lit((e - 2) % 16), (e - 1) % 16, ((e - 1) % 16) == 0, "bar");
        run(34);

        // trail on rotate, pause after 3 steps
        mode = 2'd1; speed = 2'd0; trail_en = 1'b1;
        do_reset();
        for (int e = 1; e <= 4; e++)
            push(0, 8'h00, e - 1, 0, "trail_run");
        run(4);
        enable = 1'b0;
        c_head = 0; c_h1 = 0; c_h2 = 0; c_other = 0;
        for (int i = 0; i < 16; i++) begin
            push(0, 8'h00, 3, 0, "pause");
            run(1);
            if (!display[3]) c_head++;
            if (!display[2]) c_h1++;
            if (!display[1]) c_h2++;
            if ((~display & 8'hF1) != 8'h00) c_other++;
        end
        check("trail_head", c_head, 16);
        check("trail_hist1", c_h1, 4);
        check("trail_hist2", c_h2, 1);
        check("trail_other", c_other, 0);
        enable = 1'b1; trail_en = 1'b0;

        // bounce to step 9, then switch to blink
        mode = 2'd0;
        do_reset();
        for (int e = 1; e <= 9; e++)
            push(1, ~onehot(bounce_pos((e - 1) % 14)), e % 14, 0, "pre_blink");
        run(9);
        mode = 2'd3;
        push(0, 8'h00, 0, 0, "blink_chg");
        for (int e = 11; e <= 20; e++)
            push(1, (((e - 11) % 2) == 0) ? 8'h00 : 8'hFF, (e - 10) % 2, ((e - 10) % 2) == 0, "blink");
        run(11);

        // asynchronous reset mid-sweep
        mode = 2'd0;
        do_reset();
        for (int e = 1; e <= 5; e++)
            push(1, ~onehot(bounce_pos((e - 1) % 14)), e % 14, 0, "pre_arst");
        run(5);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_disp", {24'd0, display}, 32'hFF);
        check("arst_step", {26'd0, step}, 32'd0);
        check("arst_cd", {31'd0, cycle_done}, 32'd0);
        check("sb_drained", sb.size(), 0);
        @(negedge clk);
        rstn = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
